bcd_decrementor: RTL

BCD_DECREMENTOR -- requirements
Module: bcd_decrementor

---
 rtl/bcd_decrementor.sv | 98 +++++++++
 1 files changed

// File: rtl/bcd_decrementor.sv
// Three-digit BCD countdown timer with load, start and pause control.
// The count steps down by one every TICK_DIV RUN cycles and pulses done on reaching 000.
module bcd_decrementor #(
    parameter int TICK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [11:0] BCD_in,
    input  logic        start,
    input  logic        pause,
    output logic [11:0] BCD_out,
    output logic        busy,
    output logic        done,
    output logic        load_err
);
    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic [11:0]   dec_val;
    logic          in_ok, cnt_zero, wrap, last_tick;
    logic          ld_ok, ld_bad, zero_done, run_en;

    assign in_ok    = (BCD_in[3:0] <= 4'd9) && (BCD_in[7:4] <= 4'd9) && (BCD_in[11:8] <= 4'd9);
    assign cnt_zero = (BCD_out == 12'h000);
    assign wrap     = (presc == PS_LAST);

    // BCD borrow chain; a zero count maps to zero so a tick on 000 just finishes the run
    always_comb begin
        dec_val = 12'h000;
        if (BCD_out[3:0] != 4'd0)
            dec_val = {BCD_out[11:4], BCD_out[3:0] - 4'd1};
        else if (BCD_out[7:4] != 4'd0)
            dec_val = {BCD_out[11:8], BCD_out[7:4] - 4'd1, 4'd9};
        else if (BCD_out[11:8] != 4'd0)
            dec_val = {BCD_out[11:8] - 4'd1, 8'h99};
    end

    assign last_tick = run_en && wrap && (dec_val == 12'h000);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!load && start && !cnt_zero) state_nxt = RUN;
            RUN:     if (pause) state_nxt = HOLD;
                     else if (last_tick) state_nxt = IDLE;
            HOLD:    if (!pause) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_ok     = 1'b0;
        ld_bad    = 1'b0;
        zero_done = 1'b0;
        run_en    = 1'b0;
        if (state != RUN && load) begin
            ld_ok  = in_ok;
            ld_bad = !in_ok;
        end
        if (state == IDLE && !load && start && cnt_zero) zero_done = 1'b1;
        if (state == RUN && !pause) run_en = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            BCD_out  <= 12'h000;
            presc    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= zero_done || last_tick;
            if (ld_ok) begin
                BCD_out  <= BCD_in;
                load_err <= 1'b0;
            end else if (ld_bad) begin
                load_err <= 1'b1;
            end
            if (state == IDLE && state_nxt == RUN) begin
                presc <= '0;
            end else if (run_en) begin
                presc <= wrap ? '0 : presc + PW'(1);
                if (wrap) BCD_out <= dec_val;
            end
        end
    end
endmodule
